fx_channel_sequencer: RTL
=========================

Name: fx_channel_sequencer

Overview:
Time-multiplexes one overdrive effect instance between the left and right audio channels. On each stereo sample strobe it captures both channels and runs left, then right, through the effect's START/DONE handshake. It then presents the processed stereo pair with a one-cycle valid pulse. It sits between the codec sample interface and the effect unit, and also handles bypass, gain latching, dropped-sample counting and a DONE watchdog.

Parameters:
SAMPLE_W, 16, audio sample width in bits (two's complement)
TIMEOUT_CYCLES, 8, WAIT-state cycles without fx_done before the watchdog fires (minimum 2)
DROP_W, 8, width of the saturating dropped-sample counter

Ports:
CLK  in  1  system clock; all logic on rising edge
RESET  in  1  asynchronous, active-high reset
sample_valid  in  1  one-cycle strobe: left_in/right_in hold a new stereo pair
left_in  in  SAMPLE_W  dry left sample
right_in  in  SAMPLE_W  dry right sample
bypass  in  1  sampled at capture; 1 = skip the effect for this pair
gain_sel  in  1  sampled at capture; forwarded to fx_gain for the whole pair
clear_err  in  1  clears timeout_err and drop_count
fx_start  out  1  START to the effect unit
fx_gain  out  1  gain to the effect unit
fx_input_frame  out  SAMPLE_W  input_frame to the effect unit
fx_done  in  1  DONE from the effect unit
fx_output_frame  in  SAMPLE_W  output_frame from the effect unit
left_out  out  SAMPLE_W  processed left sample (registered)
right_out  out  SAMPLE_W  processed right sample (registered)
out_valid  out  1  one-cycle pulse: left_out/right_out are updated
busy  out  1  high in every state except IDLE
timeout_err  out  1  sticky; set when the watchdog fires
drop_count  out  DROP_W  saturating count of strobes ignored while busy

Behaviour:
- Reset (async, any state): state=IDLE. All outputs and internal registers are 0, including fx_start, out_valid, timeout_err, drop_count and the sample/gain latches.
- States: IDLE, START_L, WAIT_L, START_R, WAIT_R, OUTPUT.
- IDLE with sample_valid=1: latch left_in, right_in, gain_sel and bypass. Go to OUTPUT if bypass=1, otherwise START_L.
- START_L: fx_start=1 for exactly this cycle. fx_input_frame=latched left. Next state WAIT_L.
- WAIT_L: fx_start=0. fx_input_frame stays on left. When fx_done=1, capture fx_output_frame into the left result and go to START_R.
- START_R and WAIT_R: identical to START_L and WAIT_L, using the latched right sample and right result. WAIT_R exits to OUTPUT.
- OUTPUT: register the results into left_out/right_out. Bypass pairs use the latched dry samples. out_valid=1 in the following cycle only. Return to IDLE.
- out_valid is a registered pulse, asserted in the cycle after OUTPUT.
- fx_gain equals the latched gain for the whole pair. It holds its value in IDLE.
- Latency with an effect that returns DONE in the cycle after START: out_valid is high 6 edges after the edge that samples sample_valid. For a bypassed pair, out_valid is high 2 edges after that edge.
- Watchdog: the counter clears on entry to WAIT_L/WAIT_R and increments each WAIT cycle without fx_done. On reaching TIMEOUT_CYCLES:
  - substitute the dry sample for that channel;
  - set timeout_err;
  - proceed as if fx_done had arrived.
- fx_done outside WAIT states is ignored.
- sample_valid while busy=1: the pair is dropped and drop_count increments, saturating at all-ones. The sequence in progress is not disturbed.
- A sample_valid in the same cycle that OUTPUT returns to IDLE is also dropped. The state is still OUTPUT in that cycle.
- clear_err=1 clears timeout_err and drop_count. If clear_err and a set/increment event occur in the same cycle, the set/increment wins (timeout_err=1, drop_count=1).

Decomposition:
- Shared package fx_ctrl_pkg: state enum fx_seq_state_t, SAMPLE_W default constant, and clip constants for the overdrive effect (16'h3fff/16'hbfff for gain 1, 16'h0fff/16'h8fff for gain 0), used by the bench model.
- One natural sub-module: fx_watchdog. It is a cycle counter with clear, enable, parameterised limit, and a one-cycle expired output.

Test Plan:
- Overdrive unit attached, gain_sel=1, L=16'h5000, R=16'hA000 -> left_out=16'h3fff, right_out=16'hbfff, out_valid pulse 6 edges after the strobe, fx_start pulsed exactly twice.
- gain_sel=0, L=16'h0800, R=16'h8000 -> left_out=16'h0800, right_out=16'h8fff; fx_gain=0 throughout the pair.
- bypass=1, L=16'h7fff, R=16'h8000 -> outputs equal the inputs, no fx_start, out_valid 2 edges after the strobe.
- fx_done tied 0, TIMEOUT_CYCLES=8, L=16'h1234 -> left_out=16'h1234, timeout_err=1 and sticky; clear_err clears it.
- Strobe every cycle for 300 cycles -> drop_count saturates at 8'hFF; every accepted pair produces correct outputs.
- RESET asserted mid-WAIT_R -> all outputs 0 immediately, state IDLE; the next strobe completes normally.

Source files
------------

// File: rtl/fx_ctrl_pkg.sv
// Shared types and constants for the effect channel sequencer and its overdrive partner.
package fx_ctrl_pkg;

  localparam int unsigned SAMPLE_W_DEF = 16;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_START_L = 3'd1,
    ST_WAIT_L  = 3'd2,
    ST_START_R = 3'd3,
    ST_WAIT_R  = 3'd4,
    ST_OUTPUT  = 3'd5
  } fx_seq_state_t;

  // Overdrive clip rails, signed 16-bit, selected by gain
  localparam logic [15:0] CLIP_HI_G1 = 16'h3fff;
  localparam logic [15:0] CLIP_LO_G1 = 16'hbfff;
  localparam logic [15:0] CLIP_HI_G0 = 16'h0fff;
  localparam logic [15:0] CLIP_LO_G0 = 16'h8fff;

endpackage

// File: rtl/fx_watchdog.sv
// Cycle counter for the DONE wait: cleared by clr, counts while en, flags the LIMIT-th counted cycle.
module fx_watchdog
  import fx_ctrl_pkg::*;
#(
  parameter int unsigned LIMIT = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired_c
);

  localparam int unsigned CNT_W = $clog2(LIMIT + 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Fires in the cycle that would bring the count up to LIMIT
  assign expired_c = en && (cnt_q == CNT_W'(LIMIT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/fx_channel_sequencer.sv
// Shares one effect unit between left and right: capture a stereo pair, run L then R
// through START/DONE, and present the processed pair with a one-cycle valid pulse.
module fx_channel_sequencer
  import fx_ctrl_pkg::*;
#(
  parameter int unsigned SAMPLE_W       = SAMPLE_W_DEF,
  parameter int unsigned TIMEOUT_CYCLES = 8,
  parameter int unsigned DROP_W         = 8
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic                sample_valid,
  input  logic [SAMPLE_W-1:0] left_in,
  input  logic [SAMPLE_W-1:0] right_in,
  input  logic                bypass,
  input  logic                gain_sel,
  input  logic                clear_err,
  output logic                fx_start,
  output logic                fx_gain,
  output logic [SAMPLE_W-1:0] fx_input_frame,
  input  logic                fx_done,
  input  logic [SAMPLE_W-1:0] fx_output_frame,
  output logic [SAMPLE_W-1:0] left_out,
  output logic [SAMPLE_W-1:0] right_out,
  output logic                out_valid,
  output logic                busy,
  output logic                timeout_err,
  output logic [DROP_W-1:0]   drop_count
);

  fx_seq_state_t state_q, state_d;

  logic [SAMPLE_W-1:0] left_lat_q, left_lat_d;
  logic [SAMPLE_W-1:0] right_lat_q, right_lat_d;
  logic [SAMPLE_W-1:0] res_l_q, res_l_d;
  logic [SAMPLE_W-1:0] res_r_q, res_r_d;
  logic [SAMPLE_W-1:0] fx_input_frame_q, fx_input_frame_d;
  logic [SAMPLE_W-1:0] left_out_q, left_out_d;
  logic [SAMPLE_W-1:0] right_out_q, right_out_d;
  logic                bypass_lat_q, bypass_lat_d;
  logic                gain_lat_q, gain_lat_d;
  logic                fx_start_q, fx_start_d;
  logic                out_valid_q, out_valid_d;
  logic                busy_q, busy_d;
  logic                timeout_err_q, timeout_err_d;
  logic [DROP_W-1:0]   drop_count_q, drop_count_d;
  logic [DROP_W-1:0]   drop_base_c;

  logic wd_clr_c;
  logic wd_en_c;
  logic wd_exp_c;
  logic timeout_set_c;
  logic drop_ev_c;

  fx_watchdog #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk       (CLK),
    .rst       (RESET),
    .clr       (wd_clr_c),
    .en        (wd_en_c),
    .expired_c (wd_exp_c)
  );

  always_comb begin
    state_d          = state_q;
    left_lat_d       = left_lat_q;
    right_lat_d      = right_lat_q;
    res_l_d          = res_l_q;
    res_r_d          = res_r_q;
    bypass_lat_d     = bypass_lat_q;
    gain_lat_d       = gain_lat_q;
    left_out_d       = left_out_q;
    right_out_d      = right_out_q;
    fx_input_frame_d = fx_input_frame_q;
    out_valid_d      = 1'b0;
    wd_clr_c         = 1'b0;
    wd_en_c          = 1'b0;
    timeout_set_c    = 1'b0;
    drop_ev_c        = sample_valid && (state_q != ST_IDLE);

    case (state_q)
      ST_IDLE: begin
        if (sample_valid) begin
          left_lat_d   = left_in;
          right_lat_d  = right_in;
          gain_lat_d   = gain_sel;
          bypass_lat_d = bypass;
          state_d      = bypass ? ST_OUTPUT : ST_START_L;
        end
      end
      ST_START_L: begin
        wd_clr_c = 1'b1;
        state_d  = ST_WAIT_L;
      end
      ST_WAIT_L: begin
        wd_en_c = !fx_done;
        if (fx_done) begin
          res_l_d = fx_output_frame;
          state_d = ST_START_R;
        end else if (wd_exp_c) begin
          res_l_d       = left_lat_q;
          timeout_set_c = 1'b1;
          state_d       = ST_START_R;
        end
      end
      ST_START_R: begin
        wd_clr_c = 1'b1;
        state_d  = ST_WAIT_R;
      end
      ST_WAIT_R: begin
        wd_en_c = !fx_done;
        if (fx_done) begin
          res_r_d = fx_output_frame;
          state_d = ST_OUTPUT;
        end else if (wd_exp_c) begin
          res_r_d       = right_lat_q;
          timeout_set_c = 1'b1;
          state_d       = ST_OUTPUT;
        end
      end
      ST_OUTPUT: begin
        left_out_d  = bypass_lat_q ? left_lat_q : res_l_q;
        right_out_d = bypass_lat_q ? right_lat_q : res_r_q;
        out_valid_d = 1'b1;
        state_d     = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Effect-facing outputs follow the state being entered so they are registered
    fx_start_d = (state_d == ST_START_L) || (state_d == ST_START_R);
    busy_d     = (state_d != ST_IDLE);
    case (state_d)
      ST_START_L, ST_WAIT_L: fx_input_frame_d = left_lat_d;
      ST_START_R, ST_WAIT_R: fx_input_frame_d = right_lat_d;
      default:               fx_input_frame_d = fx_input_frame_q;
    endcase

    // Set/increment wins over a simultaneous clear
    timeout_err_d = timeout_set_c || (timeout_err_q && !clear_err);
    drop_base_c   = clear_err ? '0 : drop_count_q;
    drop_count_d  = drop_base_c;
    if (drop_ev_c && (drop_base_c != {DROP_W{1'b1}})) begin
      drop_count_d = drop_base_c + DROP_W'(1);
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q          <= ST_IDLE;
      left_lat_q       <= '0;
      right_lat_q      <= '0;
      res_l_q          <= '0;
      res_r_q          <= '0;
      bypass_lat_q     <= 1'b0;
      gain_lat_q       <= 1'b0;
      left_out_q       <= '0;
      right_out_q      <= '0;
      fx_input_frame_q <= '0;
      fx_start_q       <= 1'b0;
      out_valid_q      <= 1'b0;
      busy_q           <= 1'b0;
      timeout_err_q    <= 1'b0;
      drop_count_q     <= '0;
    end else begin
      state_q          <= state_d;
      left_lat_q       <= left_lat_d;
      right_lat_q      <= right_lat_d;
      res_l_q          <= res_l_d;
      res_r_q          <= res_r_d;
      bypass_lat_q     <= bypass_lat_d;
      gain_lat_q       <= gain_lat_d;
      left_out_q       <= left_out_d;
      right_out_q      <= right_out_d;
      fx_input_frame_q <= fx_input_frame_d;
      fx_start_q       <= fx_start_d;
      out_valid_q      <= out_valid_d;
      busy_q           <= busy_d;
      timeout_err_q    <= timeout_err_d;
      drop_count_q     <= drop_count_d;
    end
  end

  assign fx_start       = fx_start_q;
  assign fx_gain        = gain_lat_q;
  assign fx_input_frame = fx_input_frame_q;
  assign left_out       = left_out_q;
  assign right_out      = right_out_q;
  assign out_valid      = out_valid_q;
  assign busy           = busy_q;
  assign timeout_err    = timeout_err_q;
  assign drop_count     = drop_count_q;

endmodule
